// File: rtl/control_unit.sv
// Multicycle FETCH/EXEC sequencer for the 8-bit accumulator datapath: owns pc, ir, flags and load enables.
// Optional retired-instruction counter enabled by defining CTRL_ICOUNT_EN; otherwise icount is tied to zero.
module control_unit #(
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  input  logic [8:0]          imem_data,
  input  logic [7:0]          alu_out,
  input  logic                alu_carry,
  output logic [PC_WIDTH-1:0] pc,
  output logic [8:0]          ir,
  output logic                load_a,
  output logic                load_b,
  output logic                flag_z,
  output logic                flag_c,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         icount
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  state_t              state_reg, state_next;
  logic                single_reg, single_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [8:0]          ir_reg;
  logic                z_reg, c_reg;
  logic                is_data, is_halt, take_jump;
  logic [PC_WIDTH-1:0] target;

  assign target = PC_WIDTH'(ir_reg[3:0]);

  // Instruction decode from the registered ir
  always_comb begin
    is_data   = (ir_reg[7:6] != 2'b00);
    is_halt   = !is_data && (ir_reg[5:4] == 2'b11);
    take_jump = 1'b0;
    if (!is_data) begin
      case (ir_reg[5:4])
        2'b01:   take_jump = 1'b1;
        2'b10:   take_jump = ir_reg[8] ? !z_reg : z_reg;
        default: take_jump = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    single_next = single_reg;
    pc_next     = pc_reg;
    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next  = FETCH;
          single_next = 1'b0;
        end else if (step) begin
          state_next  = FETCH;
          single_next = 1'b1;
        end
      end
      FETCH: state_next = EXEC;
      EXEC: begin
        if (!is_halt)
          pc_next = take_jump ? target : pc_reg + PC_WIDTH'(1);
        if (is_halt)
          state_next = HALTED;
        else if (single_reg || !run)
          state_next = IDLE;
        else
          state_next = FETCH;
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      single_reg <= 1'b0;
      pc_reg     <= '0;
      ir_reg     <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      single_reg <= single_next;
      if (state_reg == FETCH)
        ir_reg <= imem_data;
      if (state_reg == EXEC) begin
        pc_reg <= pc_next;
        // Control instructions leave the flags untouched
        if (is_data) begin
          z_reg <= (alu_out == 8'h00);
          c_reg <= alu_carry;
        end
      end
    end
  end

`ifdef CTRL_ICOUNT_EN
  logic [15:0] icount_reg;
  always_ff @(posedge clk) begin
    if (rst)
      icount_reg <= '0;
    else if (state_reg == EXEC && icount_reg != 16'hFFFF)
      icount_reg <= icount_reg + 16'd1;
  end
  assign icount = icount_reg;
`else
  assign icount = 16'h0000;
`endif

  assign pc     = pc_reg;
  assign ir     = ir_reg;
  assign flag_z = z_reg;
  assign flag_c = c_reg;
  assign busy   = (state_reg == FETCH) || (state_reg == EXEC);
  assign halted = (state_reg == HALTED);
  // Enables are gated by rst so a reset cycle never loads the datapath
  assign load_a = (state_reg == EXEC) && ir_reg[6] && !rst;
  assign load_b = (state_reg == EXEC) && ir_reg[7] && !rst;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a program-level reference model queues expected retirements,
// and a monitor pops and compares one record per observed EXEC cycle.
`timescale 1ns/1ps
module tb_control_unit;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [8:0]    imem_data;
  logic [7:0]    alu_out;
  logic          alu_carry;
  logic [PW-1:0] pc;
  logic [8:0]    ir;
  logic          load_a, load_b, flag_z, flag_c, busy, halted;
  logic [15:0]   icount;

  logic [8:0] imem      [16];
  logic [7:0] alu_mem   [16];
  logic       carry_mem [16];

  // Instruction memory and a stand-in datapath, both addressed by the current pc
  assign imem_data = imem[pc];
  assign alu_out   = alu_mem[pc];
  assign alu_carry = carry_mem[pc];

  control_unit #(.PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .imem_data(imem_data), .alu_out(alu_out), .alu_carry(alu_carry),
    .pc(pc), .ir(ir), .load_a(load_a), .load_b(load_b),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .halted(halted),
    .icount(icount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] ir;
    logic       la;
    logic       lb;
    logic [3:0] pc;
    logic       z;
    logic       c;
    logic       h;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  bit         pending = 1'b0;
  bit         mon_en = 1'b0;
  bit         phase = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] model_pc;
  logic       model_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the program by the instruction rules, from pc=0 with cleared flags
  function automatic int model(input int k);
    logic [3:0] p = 4'd0;
    logic z = 1'b0, c = 1'b0, h = 1'b0, take;
    logic [8:0] w;
    exp_t e;
    int n = 0;
    while (n < k && !h) begin
      w = imem[p];
      if (w[7:6] != 2'b00) begin
        z = (alu_mem[p] == 8'h00);
        c = carry_mem[p];
        p = p + 4'd1;
      end else begin
        case (w[5:4])
          2'b00: p = p + 4'd1;
          2'b01: p = w[3:0];
          2'b10: begin
            take = w[8] ? !z : z;
            p = take ? w[3:0] : p + 4'd1;
          end
          default: h = 1'b1;
        endcase
      end
      e.ir = w; e.la = w[6]; e.lb = w[7]; e.pc = p; e.z = z; e.c = c; e.h = h;
      q.push_back(e);
      n++;
    end
    model_pc = p;
    model_halted = h;
    return n;
  endfunction

  // Monitor: tracks FETCH/EXEC alternation from busy, checks each retirement
  always @(negedge clk) begin
    if (pending) begin
      pending = 1'b0;
      chk("pc_after", 32'(pc), 32'(cur.pc));
      chk("flag_z", 32'(flag_z), 32'(cur.z));
      chk("flag_c", 32'(flag_c), 32'(cur.c));
      chk("halted", 32'(halted), 32'(cur.h));
    end
    if (rst || !busy) phase = 1'b0;
    else if (!phase) phase = 1'b1;
    else begin
      phase = 1'b0;
      if (mon_en) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got ir=%03h at pc=%0d, expected no instruction", ir, pc);
        end else begin
          cur = q.pop_front();
          $display("retire ir=%03h pc=%0d -> pc=%0d z=%0d c=%0d h=%0d", cur.ir, pc, cur.pc, cur.z, cur.c, cur.h);
          chk("ir", 32'(ir), 32'(cur.ir));
          chk("load_a", 32'(load_a), 32'(cur.la));
          chk("load_b", 32'(load_b), 32'(cur.lb));
          pending = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    @(posedge clk); #1;
    chk("rst_load_a", 32'(load_a), 32'd0);
    chk("rst_load_b", 32'(load_b), 32'd0);
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_flags", 32'({flag_z, flag_c}), 32'd0);
    chk("rst_busy_halted", 32'({busy, halted}), 32'd0);
    chk("rst_icount", 32'(icount), 32'd0);
    rst = 1'b0;
    q.delete();
    pending = 1'b0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while ((q.size() != 0 || pending || busy) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain_done", 32'(t < 200), 32'd1);
`ifdef CTRL_ICOUNT_EN
    chk("icount", 32'(icount), 32'(n));
`else
    chk("icount", 32'(icount), 32'd0);
`endif
    chk("halted_final", 32'(halted), 32'(model_halted));
    chk("pc_final", 32'(pc), 32'(model_pc));
    if (model_halted) begin
      run = 1'b1; step = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("halt_sticky", 32'({halted, busy}), 32'b10);
      chk("halt_pc", 32'(pc), 32'(model_pc));
      run = 1'b0; step = 1'b0;
    end
    mon_en = 1'b0;
  endtask

  // Continuous run: run held exactly long enough for k instructions to retire
  task automatic run_prog(input int k, input bit with_step);
    int n;
    do_reset();
    n = model(k);
    mon_en = 1'b1;
    @(negedge clk);
    run = 1'b1; step = with_step;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (2 * k - 2) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    drain(n);
  endtask

  task automatic step_prog(input int k, input bit glitch);
    int n, t;
    do_reset();
    n = model(k);
    mon_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step = 1'b1;
      @(posedge clk); #1;
      if (i == 0 && glitch) begin
        @(posedge clk); #1;
      end
      step = 1'b0;
      t = 0;
      while ((busy || pending) && t < 50) begin
        @(negedge clk); #1;
        t++;
      end
    end
    drain(n);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      imem[i] = 9'h000; alu_mem[i] = 8'h11; carry_mem[i] = 1'b0;
    end
    // All-NOP wrap past the top address
    run_prog(17, 1'b0);
    // Unconditional jump
    imem[0] = 9'h019;
    run_prog(1, 1'b0);
    // Data load then JEQ/JNE
    imem[0] = 9'h143; imem[1] = 9'h025; alu_mem[0] = 8'h00; carry_mem[0] = 1'b1;
    run_prog(2, 1'b0);
    alu_mem[0] = 8'h07; carry_mem[0] = 1'b0;
    run_prog(2, 1'b0);
    imem[1] = 9'h125;
    run_prog(2, 1'b0);
    // HALT after three instructions; extra budget must not matter
    imem[1] = 9'h025; imem[2] = 9'h030;
    run_prog(6, 1'b0);
    // Single-step, step glitch in FETCH, run+step together
    for (int i = 0; i < 16; i++) imem[i] = 9'h000;
    imem[0] = 9'h0C5; alu_mem[0] = 8'h00; carry_mem[0] = 1'b1;
    step_prog(1, 1'b0);
    step_prog(3, 1'b1);
    run_prog(4, 1'b1);
    // Randomized programs in all three modes
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 16; i++) begin
        imem[i] = 9'($urandom_range(0, 511));
        alu_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        carry_mem[i] = 1'($urandom_range(0, 1));
      end
      case (r % 3)
        0: run_prog($urandom_range(3, 20), 1'b0);
        1: run_prog($urandom_range(3, 20), 1'b1);
        default: step_prog($urandom_range(2, 6), 1'($urandom_range(0, 1)));
      endcase
    end
    // Reset during EXEC of a load-A instruction: no load, no commit
    do_reset();
    imem[0] = 9'h143; alu_mem[0] = 8'h00; carry_mem[0] = 1'b1;
    @(negedge clk); run = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    chk("exec_load_a", 32'(load_a), 32'd1);
    rst = 1'b1; run = 1'b0;
    #1;
    chk("rst_exec_load_a", 32'(load_a), 32'd0);
    @(negedge clk);
    chk("rst_exec_pc", 32'(pc), 32'd0);
    chk("rst_exec_ir", 32'(ir), 32'd0);
    chk("rst_exec_flags", 32'({flag_z, flag_c}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
